// File: rtl/hw_stack_pkg.sv
// Shared definitions for the hardware LIFO: default geometry and the decoded stack operation.
package hw_stack_pkg;

    localparam int unsigned STACK_DATA_W = 8;
    localparam int unsigned STACK_DEPTH  = 16;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        PUSH    = 2'b01,
        POP     = 2'b10,
        REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push_en, input logic pop_en);
        return stack_op_e'({pop_en, push_en});
    endfunction

endpackage

// File: rtl/hw_stack_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port,
// plus a second read port when HW_STACK_PEEK_EN is defined. Contents are not reset.
module hw_stack_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
`ifdef HW_STACK_PEEK_EN
    ,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
`endif
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

`ifdef HW_STACK_PEEK_EN
    assign rdata2_o = mem_q[raddr2_i];
`endif

endmodule

// File: rtl/hw_stack.sv
// Parametrised LIFO with zero-latency top-of-stack, replace-top on push+pop and sticky error flags.
// Optional stack-relative peek port enabled by defining HW_STACK_PEEK_EN.
module hw_stack
    import hw_stack_pkg::*;
#(
    parameter int unsigned DATA_W = STACK_DATA_W,
    parameter int unsigned DEPTH  = STACK_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_enable,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_enable,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clear
`ifdef HW_STACK_PEEK_EN
    ,
    input  logic [CNT_W-1:0]  peek_idx,
    output logic [DATA_W-1:0] peek_data
`endif
);

    localparam int unsigned       ADDR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    stack_op_e         op;
    logic              is_empty, is_full;
    logic [CNT_W-1:0]  top_idx;
    logic [ADDR_W-1:0] top_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] top_data;

    assign op       = decode_op(push_enable, pop_enable);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign top_idx  = count_q - CNT_W'(1);
    assign top_addr = ADDR_W'(top_idx);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q & ~err_clear;
        unf_d   = unf_q & ~err_clear;
        wr_en   = 1'b0;
        wr_addr = ADDR_W'(count_q);
        unique case (op)
            PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = top_idx;
                end
            end
            REPLACE: begin
                // On an empty stack this degenerates to a plain push into slot 0.
                wr_en = 1'b1;
                if (is_empty) begin
                    count_d = CNT_W'(1);
                end else begin
                    wr_addr = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef HW_STACK_PEEK_EN
    logic [ADDR_W-1:0] peek_addr;
    logic [DATA_W-1:0] peek_raw;
    assign peek_addr = ADDR_W'(top_idx - peek_idx);
`endif

    // Storage writes are suppressed while reset is held so a discarded push leaves no trace.
    hw_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i    (clk),
        .we_i     (wr_en & rst),
        .waddr_i  (wr_addr),
        .wdata_i  (push_data),
        .raddr_i  (top_addr),
        .rdata_o  (top_data)
`ifdef HW_STACK_PEEK_EN
        ,
        .raddr2_i (peek_addr),
        .rdata2_o (peek_raw)
`endif
    );

`ifdef HW_STACK_PEEK_EN
    assign peek_data = (peek_idx < count_q) ? peek_raw : '0;
`endif

    assign pop_data  = is_empty ? '0 : top_data;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_hw_stack.sv
// Self-checking bench for hw_stack: queue-based reference model plus directed literal checks.
// Peek checks are compiled in when HW_STACK_PEEK_EN is defined.
module tb_hw_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_enable = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop_enable = 1'b0;
    logic [DW-1:0] pop_data;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;
    logic          err_clear = 1'b0;
`ifdef HW_STACK_PEEK_EN
    logic [CW-1:0] peek_idx = '0;
    logic [DW-1:0] peek_data;
`endif

    hw_stack dut (
        .clk         (clk),
        .rst         (rst),
        .push_enable (push_enable),
        .push_data   (push_data),
        .pop_enable  (pop_enable),
        .pop_data    (pop_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clear   (err_clear)
`ifdef HW_STACK_PEEK_EN
        ,
        .peek_idx    (peek_idx),
        .peek_data   (peek_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue whose back is the top.
    logic [DW-1:0] m_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            chk_en = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_top();
        if (m_q.size() == 0) return '0;
        return m_q[m_q.size()-1];
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic m_update(input bit p, input logic [DW-1:0] d, input bit q, input bit c);
        bit so = 1'b0;
        bit su = 1'b0;
        int n  = m_q.size();
        if (p && q) begin
            if (n > 0) m_q[n-1] = d;
            else       m_q.push_back(d);
        end else if (p) begin
            if (n == DEPTH) so = 1'b1;
            else            m_q.push_back(d);
        end else if (q) begin
            if (n == 0) su = 1'b1;
            else        void'(m_q.pop_back());
        end
        m_ovf = (c ? 1'b0 : m_ovf) | so;
        m_unf = (c ? 1'b0 : m_unf) | su;
    endtask

    // Compare process: outputs depend only on state (and peek_idx), so check mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_count",     32'(count),     32'(m_q.size()));
            chk("cyc_empty",     32'(empty),     32'(m_q.size() == 0));
            chk("cyc_full",      32'(full),      32'(m_q.size() == DEPTH));
            chk("cyc_overflow",  32'(overflow),  32'(m_ovf));
            chk("cyc_underflow", 32'(underflow), 32'(m_unf));
            chk("cyc_pop_data",  32'(pop_data),  32'(m_top()));
`ifdef HW_STACK_PEEK_EN
            if (int'(peek_idx) < m_q.size())
                chk("cyc_peek", 32'(peek_data), 32'(m_q[m_q.size()-1-int'(peek_idx)]));
            else
                chk("cyc_peek", 32'(peek_data), 32'd0);
`endif
        end
    end

    task automatic step(input bit p, input logic [DW-1:0] d, input bit q, input bit c);
        push_enable = p;
        push_data   = d;
        pop_enable  = q;
        err_clear   = c;
        @(posedge clk);
        if (rst) m_update(p, d, q, c);
        #1;
        push_enable = 1'b0;
        pop_enable  = 1'b0;
        err_clear   = 1'b0;
    endtask

    initial begin
        #3 rst = 1'b0;
        m_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_flags", 32'({overflow, underflow}), 32'd0);
        chk("rst_pop",   32'(pop_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Basic push/pop ordering.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_top33",  32'(pop_data), 32'h33);
        step(0, 8'h00, 1, 0);
        chk("t1_top22",  32'(pop_data), 32'h22);
        chk("t1_count2", 32'(count), 32'd2);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t1_empty",  32'(empty), 32'd1);
        chk("t1_pop0",   32'(pop_data), 32'd0);

        // Fill, overflow, clear.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
        chk("t2_full", 32'(full), 32'd1);
        step(1, 8'hAA, 0, 0);
        chk("t2_ovf",   32'(overflow), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        chk("t2_top",   32'(pop_data), 32'h0F);
        step(0, 8'h00, 0, 1);
        chk("t2_ovf_clr", 32'(overflow), 32'd0);

        // Underflow; set wins over clear.
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t3_unf",   32'(underflow), 32'd1);
        chk("t3_count", 32'(count), 32'd0);
        step(0, 8'h00, 1, 1);
        chk("t3_unf_setwins", 32'(underflow), 32'd1);
        step(0, 8'h00, 0, 1);
        chk("t3_unf_clr", 32'(underflow), 32'd0);

        // Replace-top, including on a full stack.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h99, 1, 0);
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_top",   32'(pop_data), 32'h99);
        for (int i = 0; i < DEPTH - 2; i++) step(1, 8'(8'h40 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        chk("t4_full_noovf", 32'(overflow), 32'd0);
        chk("t4_full_top",   32'(pop_data), 32'h77);
        chk("t4_full_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);

        // Push+pop on empty behaves as push.
        step(1, 8'h5A, 1, 0);
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_top",   32'(pop_data), 32'h5A);
        chk("t5_nounf", 32'(underflow), 32'd0);
        step(0, 8'h00, 1, 0);

`ifdef HW_STACK_PEEK_EN
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        peek_idx = 5'd0; #1;
        chk("t6_peek0", 32'(peek_data), 32'h33);
        peek_idx = 5'd2; #1;
        chk("t6_peek2", 32'(peek_data), 32'h11);
        peek_idx = 5'd3; #1;
        chk("t6_peek3", 32'(peek_data), 32'h00);
        repeat (3) step(0, 8'h00, 1, 0);
`endif

        // Reset asserted in the middle of a push cycle.
        step(0, 8'h00, 1, 0);
        step(1, 8'h55, 0, 0);
        push_enable = 1'b1;
        push_data   = 8'h44;
        #2 rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        push_enable = 1'b0;
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_flags", 32'({overflow, underflow}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(0, 8'h00, 0, 0);
        chk("rstmid_after_count", 32'(count), 32'd0);
        chk("rstmid_after_pop",   32'(pop_data), 32'd0);

        // Randomised phases: push-heavy, pop-heavy, balanced.
        for (int ph = 0; ph < 3; ph++) begin
            int pp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            int qp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            for (int i = 0; i < 800; i++) begin
                bit p = ($urandom_range(0, 99) < pp);
                bit q = ($urandom_range(0, 99) < qp);
                bit c = ($urandom_range(0, 15) == 0);
`ifdef HW_STACK_PEEK_EN
                peek_idx = CW'($urandom_range(0, 18));
`endif
                step(p, 8'($urandom), q, c);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
